adc_spi_sequencer: RTL and testbench
====================================

# adc_spi_sequencer

Periodic sample sequencer for the audio input ADC (MCP3002-style, 10-bit, 2-channel). It sits directly upstream of the byte-wide SPI master: it generates the sample-rate tick, issues the two-byte conversion command through the master's `start`/`data_in` handshake, and collects the two returned bytes from `data_out`/`new_data`. It then presents one 10-bit sample with a single-cycle valid strobe to the audio processing chain.

## Interface
- `SAMPLE_PERIOD`, default 1134: clk cycles between conversion requests (50 MHz / 1134 ≈ 44.1 kHz). Legal range is 40..65535.
- `CHANNEL`, default 0: ADC channel select, 0 or 1.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `enable`, input, 1: run sampling while high.
- `spi_start`, output, 1: single-cycle transaction request to the SPI master.
- `spi_data_in`, output, 8: byte to transmit; stable from the `spi_start` cycle until `spi_new_data`.
- `spi_busy`, input, 1: SPI master busy.
- `spi_data_out`, input, 8: byte received by the SPI master.
- `spi_new_data`, input, 1: single-cycle strobe; `spi_data_out` is valid in that cycle.
- `sample`, output, 10: last completed conversion.
- `sample_valid`, output, 1: single-cycle strobe marking a new `sample`.
- `overrun`, output, 1: sticky flag; a tick arrived while a conversion was still in progress.
- `overrun_clr`, input, 1: synchronous clear for `overrun`.

## Operation
- Tick counter:
  - Counts 0..SAMPLE_PERIOD-1 while `enable`=1, then wraps and raises a one-cycle internal tick on the wrap.
  - Held at 0 while `enable`=0.
- States and transitions:
  - IDLE → START0 on tick.
  - START0 → WAIT0 on the cycle `spi_start` is issued.
  - WAIT0 → START1 on `spi_new_data`; capture `spi_data_out[1:0]` as D9..D8.
  - START1 → WAIT1 on the cycle `spi_start` is issued.
  - WAIT1 → DONE on `spi_new_data`; capture `spi_data_out` as D7..D0.
  - DONE → IDLE unconditionally; `sample` is updated and `sample_valid`=1 in this state.
- Transmit bytes:
  - byte0 = {1'b0, 1'b1 start, 1'b1 single-ended, CHANNEL[0], 1'b1 MSB-first, 3'b000}.
  - byte1 = 8'h00.
- `spi_start` handshake:
  - Asserted only in START0/START1, for exactly one cycle, and only when `spi_busy`=0.
  - If `spi_busy`=1, the FSM holds in START with `spi_start`=0.
- Overrun:
  - A tick in any state other than IDLE is dropped and sets `overrun`=1.
  - If `overrun_clr` and an overrun event occur in the same cycle, set wins.
- `enable` falling mid-conversion: the conversion in progress completes and is delivered; no further ticks.
- `spi_new_data` outside WAIT0/WAIT1 is ignored.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `spi_start`=0, `spi_data_in`=8'h00.
  - `sample`=10'd0, `sample_valid`=0, `overrun`=0.
- Reset mid-transaction aborts immediately. The SPI master shares `rst`, so no resynchronisation is needed.
- First tick: SAMPLE_PERIOD cycles after the first rising edge with `enable`=1.
- `spi_start` for byte0: the cycle after the tick, if the master is idle.
- `sample_valid`: exactly one cycle after the cycle the second `spi_new_data` is sampled.
- Total latency from tick to valid = 2 + (SPI time for byte0) + 1 + (SPI time for byte1) + 1 cycles.
- SAMPLE_PERIOD must exceed this latency, or every other tick overruns.

## Configuration
- `ADC_SIGNED_EN`:
  - Defined: `sample` is two's complement, {~D9, D8..D0}; midscale 512 maps to 0.
  - Undefined: `sample` is the raw offset-binary code {D9..D0}.
  - Reset value is 10'd0 in both builds.

## Structure
- Shared package `adc_pkg` holds:
  - State enum encoding (IDLE, START0, WAIT0, START1, WAIT1, DONE).
  - Command-bit constants (start, single-ended, MSB-first) and the byte1 value.
- One sub-module: `sample_tick_gen`, the period counter with enable and tick output.

## Test plan
- Byte exchange: behavioural SPI master model; CHANNEL=0; ADC returns byte0=8'h02, byte1=8'h5A. Required:
  - `spi_data_in`=8'h68, then 8'h00.
  - `sample`=10'h25A with one `sample_valid` pulse.
- Master busy: `spi_busy` held 1 for 7 cycles after the tick → `spi_start` withheld, then issued as a single pulse in the first cycle `spi_busy`=0.
- Overrun: SAMPLE_PERIOD=40 with 30-cycle SPI bytes → `overrun` rises on the 2nd tick and stays 1 until `overrun_clr`. Samples continue on alternate ticks.
- Reset mid-operation: assert `rst` during WAIT1 → all outputs are reset values in the same cycle, FSM is IDLE, and no `sample_valid` occurs.
- Enable drop: drop `enable` during WAIT0 → the conversion completes with one `sample_valid`, then no further `spi_start`.
- Signed build: with `ADC_SIGNED_EN`, codes 10'h200, 10'h000 and 10'h3FF produce `sample` = 10'h000, 10'h200 and 10'h1FF.

Source files
------------

// File: rtl/adc_spi_sequencer_pkg.sv
// Shared types and command constants for the MCP3002-style ADC sequencer.
// The package is named adc_pkg; it is imported by adc_spi_sequencer and sample_tick_gen.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_START1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic       CMD_START = 1'b1;
  localparam logic       CMD_SGL   = 1'b1;
  localparam logic       CMD_MSBF  = 1'b1;
  localparam logic [7:0] CMD_BYTE1 = 8'h00;

  localparam int unsigned TICK_CNT_W = 16;

  // First command byte: leading zero, start, single-ended, channel, MSB-first, pad.
  function automatic logic [7:0] cmd_byte0(input logic ch);
    return {1'b0, CMD_START, CMD_SGL, ch, CMD_MSBF, 3'b000};
  endfunction

endpackage

// File: rtl/adc_spi_sequencer_sample_tick_gen.sv
// Sample-rate period counter: counts 0..PERIOD-1 while enabled and pulses
// tick for one cycle on each wrap; held at zero while disabled.
module sample_tick_gen
  import adc_pkg::*;
#(
  parameter int unsigned PERIOD = 1134
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam logic [TICK_CNT_W-1:0] LAST = TICK_CNT_W'(PERIOD - 1);

  logic [TICK_CNT_W-1:0] cnt_q, cnt_d;
  logic                  tick_q, tick_d;

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == LAST) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + TICK_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // A wrap registered in the cycle enable falls must not start a conversion.
  assign tick = tick_q & enable;

endmodule

// File: rtl/adc_spi_sequencer.sv
// Periodic two-byte conversion sequencer in front of a byte-wide SPI master.
// Build option: define ADC_SIGNED_EN to present samples as two's complement.
//
// state   | meaning
// IDLE    | waiting for the sample tick
// START0  | request command byte0 once the master is idle
// WAIT0   | byte0 in flight; reply carries D9..D8
// START1  | request byte1 once the master is idle
// WAIT1   | byte1 in flight; reply carries D7..D0
// DONE    | new sample presented with sample_valid
module adc_spi_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 1134,
  parameter int unsigned CHANNEL       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       spi_start,
  output logic [7:0] spi_data_in,
  input  logic       spi_busy,
  input  logic [7:0] spi_data_out,
  input  logic       spi_new_data,
  output logic [9:0] sample,
  output logic       sample_valid,
  output logic       overrun,
  input  logic       overrun_clr
);

  localparam logic [7:0] BYTE0 = cmd_byte0(CHANNEL[0]);

  state_t     state_q, state_d;
  logic [7:0] data_in_q, data_in_d;
  logic [1:0] hi_q, hi_d;
  logic [9:0] sample_q, sample_d;
  logic       overrun_q, overrun_d;
  logic       tick;
  logic [9:0] raw_code, fmt_code;

  sample_tick_gen #(
    .PERIOD (SAMPLE_PERIOD)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  assign raw_code = {hi_q, spi_data_out};

`ifdef ADC_SIGNED_EN
  // Offset binary to two's complement: midscale 512 becomes zero.
  assign fmt_code = {~raw_code[9], raw_code[8:0]};
`else
  assign fmt_code = raw_code;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tick)          state_d = ST_START0;
      ST_START0: if (!spi_busy)     state_d = ST_WAIT0;
      ST_WAIT0:  if (spi_new_data)  state_d = ST_START1;
      ST_START1: if (!spi_busy)     state_d = ST_WAIT1;
      ST_WAIT1:  if (spi_new_data)  state_d = ST_DONE;
      ST_DONE:                      state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    spi_start    = 1'b0;
    sample_valid = 1'b0;
    case (state_q)
      ST_START0, ST_START1: spi_start    = ~spi_busy;
      ST_DONE:              sample_valid = 1'b1;
      default:              ;
    endcase
  end

  // Transmit byte is loaded on entry to each START state so it is stable
  // for the whole transaction.
  always_comb begin
    data_in_d = data_in_q;
    hi_d      = hi_q;
    sample_d  = sample_q;
    overrun_d = overrun_q;
    if (state_q == ST_IDLE && tick) begin
      data_in_d = BYTE0;
    end
    if (state_q == ST_WAIT0 && spi_new_data) begin
      data_in_d = CMD_BYTE1;
      hi_d      = spi_data_out[1:0];
    end
    if (state_q == ST_WAIT1 && spi_new_data) begin
      sample_d = fmt_code;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (tick && state_q != ST_IDLE) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_in_q <= 8'h00;
      hi_q      <= 2'b00;
      sample_q  <= 10'd0;
      overrun_q <= 1'b0;
    end else begin
      data_in_q <= data_in_d;
      hi_q      <= hi_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
    end
  end

  assign spi_data_in = data_in_q;
  assign sample      = sample_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Directed plus randomized bench for adc_spi_sequencer with a behavioural SPI
// master and ADC; expected samples come from a code-level reference model.
module tb_adc_spi_sequencer;

  localparam int P = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       spi_start;
  logic [7:0] spi_data_in;
  logic       spi_busy = 1'b0;
  logic [7:0] spi_data_out = 8'h00;
  logic       spi_new_data = 1'b0;
  logic [9:0] sample;
  logic       sample_valid;
  logic       overrun;
  logic       overrun_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int start_cnt = 0;

  adc_spi_sequencer #(
    .SAMPLE_PERIOD (P),
    .CHANNEL       (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_data_out (spi_data_out),
    .spi_new_data (spi_new_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (sample_valid === 1'b1) valid_cnt++;
    if (spi_start === 1'b1) start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: 10-bit code from the two reply bytes, then output format.
  function automatic logic [9:0] model_sample(input logic [7:0] b0, input logic [7:0] b1);
    int code;
    code = int'(b0[1:0]) * 256 + int'(b1);
`ifdef ADC_SIGNED_EN
    return 10'((code + 512) % 1024);
`else
    return 10'(code);
`endif
  endfunction

  task automatic wait_start(input int budget, output int at);
    bit ok;
    ok = 1'b0;
    at = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (spi_start === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    chk("start_seen", 32'(ok), 32'd1);
  endtask

  // Behavioural master: busy for len cycles after start, then one new_data strobe.
  task automatic serve_byte(input logic [7:0] exp_tx, input logic [7:0] resp,
                            input int len, input bit drop_en);
    logic [7:0] tx;
    tx = spi_data_in;
    chk("tx_byte", 32'(tx), 32'(exp_tx));
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      spi_busy = 1'b1;
      if (drop_en && i == 0) enable = 1'b0;
      #1;
      chk("start_single", 32'(spi_start), 32'd0);
      chk("tx_stable", 32'(spi_data_in), 32'(tx));
    end
    @(negedge clk);
    spi_busy     = 1'b0;
    spi_new_data = 1'b1;
    spi_data_out = resp;
    #1;
    chk("no_start_in_wait", 32'(spi_start), 32'd0);
    @(negedge clk);
    spi_new_data = 1'b0;
    spi_data_out = 8'($urandom);
    #1;
  endtask

  task automatic conv(input logic [7:0] b0, input logic [7:0] b1,
                      input int len0, input int len1, input bit drop_en);
    int v0;
    logic [9:0] exp_s;
    v0 = valid_cnt;
    exp_s = model_sample(b0, b1);
    serve_byte(8'h68, b0, len0, drop_en);
    chk("byte1_start", 32'(spi_start), 32'd1);
    serve_byte(8'h00, b1, len1, 1'b0);
    chk("valid", 32'(sample_valid), 32'd1);
    chk("sample", 32'(sample), 32'(exp_s));
    @(negedge clk);
    #1;
    chk("valid_once", 32'(valid_cnt - v0), 32'd1);
    chk("valid_low", 32'(sample_valid), 32'd0);
    chk("sample_hold", 32'(sample), 32'(exp_s));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"},   32'(spi_start),    32'd0);
    chk({tag, "_data_in"}, 32'(spi_data_in),  32'h00);
    chk({tag, "_sample"},  32'(sample),       32'd0);
    chk({tag, "_valid"},   32'(sample_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun),      32'd0);
  endtask

  initial begin
    int s;
    int at;
    int t0;
    int guard;
    int v0;
    int sc0;
    logic [9:0] dir_codes [3];
    logic [7:0] b0;
    logic [7:0] b1;

    dir_codes[0] = 10'h200;
    dir_codes[1] = 10'h000;
    dir_codes[2] = 10'h3FF;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // First tick P cycles after enable; byte exchange 02/5A
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc;
    wait_start(3 * P, at);
    chk("first_tick", 32'(at - t0), 32'(P + 1));
    s = at;
    conv(8'h02, 8'h5A, 3, 3, 1'b0);

    // Directed code boundaries followed by random codes and SPI timings
    for (int i = 0; i < 8; i++) begin
      wait_start(2 * P, at);
      chk("period", 32'(at - s), 32'(P));
      s = at;
      if (i < 3) begin
        b0 = {6'($urandom), dir_codes[i][9:8]};
        b1 = dir_codes[i][7:0];
      end else begin
        b0 = 8'($urandom);
        b1 = 8'($urandom);
      end
      conv(b0, b1, $urandom_range(1, 6), $urandom_range(1, 6), 1'b0);
    end

    // Master busy for 7 cycles starting at the tick
    guard = 0;
    while (cyc != s + P - 1 && guard < 2 * P) begin
      @(negedge clk);
      guard++;
    end
    spi_busy = 1'b1;
    #1;
    chk("busy_tick", 32'(spi_start), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("busy_withheld", 32'(spi_start), 32'd0);
    end
    @(negedge clk);
    spi_busy = 1'b0;
    #1;
    chk("busy_release", 32'(spi_start), 32'd1);
    chk("busy_release_time", 32'(cyc - s), 32'(P + 6));
    s = s + P;
    conv(8'($urandom), 8'($urandom), 2, 4, 1'b0);

    // Overrun: 30-cycle bytes make every other tick collide
    wait_start(2 * P, at);
    chk("period_pre_ovr", 32'(at - s), 32'(P));
    chk("ovr_before", 32'(overrun), 32'd0);
    s = at;
    conv(8'($urandom), 8'($urandom), 30, 30, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_start(3 * P, at);
    chk("ovr_alternate", 32'(at - s), 32'(2 * P));
    s = at;
    conv(8'($urandom), 8'($urandom), 30, 30, 1'b0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    #1;
    chk("ovr_clear", 32'(overrun), 32'd0);
    wait_start(3 * P, at);
    chk("ovr_alternate2", 32'(at - s), 32'(2 * P));
    s = at;
    conv(8'($urandom), 8'($urandom), 3, 3, 1'b0);
    chk("ovr_stays_clear", 32'(overrun), 32'd0);

    // Enable drop during WAIT0: conversion completes, then silence
    wait_start(2 * P, at);
    chk("period_pre_drop", 32'(at - s), 32'(P));
    conv(8'hFD, 8'hC3, 5, 5, 1'b1);
    sc0 = start_cnt;
    v0 = valid_cnt;
    repeat (3 * P) @(negedge clk);
    #3;
    chk("drop_no_start", 32'(start_cnt - sc0), 32'd0);
    chk("drop_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Reset during WAIT1
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc;
    wait_start(3 * P, at);
    chk("reenable_tick", 32'(at - t0), 32'(P + 1));
    serve_byte(8'h68, 8'h03, 4, 1'b0);
    chk("rst_byte1_start", 32'(spi_start), 32'd1);
    @(negedge clk);
    spi_busy = 1'b1;
    @(negedge clk);
    #1;
    v0 = valid_cnt;
    sc0 = start_cnt;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    spi_busy = 1'b0;
    rst = 1'b0;
    t0 = cyc;
    @(negedge clk);
    spi_new_data = 1'b1;
    spi_data_out = 8'hA5;
    @(negedge clk);
    spi_new_data = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    chk("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("midrst_no_start", 32'(start_cnt - sc0), 32'd0);
    chk("midrst_sample", 32'(sample), 32'd0);
    wait_start(3 * P, at);
    chk("post_rst_tick", 32'(at - t0), 32'(P + 1));
    conv(8'($urandom), 8'($urandom), 3, 2, 1'b0);

    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
